muldiv_sequencer: RTL and testbench

Iterative sequencer for the RV32M multiply/divide instructions (MUL, MULH, DIV, DIVU, REM, REMU) in the execute stage. It accepts one request from decode/execute and runs a 32-step shift-add multiply or restoring divide. It stalls the pipeline while busy and returns one write-back result per request. Divide-by-zero and signed overflow complete on a 1-cycle fast path with RISC-V-mandated results.

---
 rtl/muldiv_sequencer_if.sv | 39 +++
 rtl/muldiv_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
// Request / response / pipeline-control bundle between the execute stage and
// the iterative RV32M multiply/divide sequencer.
//   req_valid/req_ready  : request handshake (accepted when both high, no flush)
//   req_func3/req_rd     : operation select and destination register
//   req_rs1_val/rs2_val  : operand a (multiplicand/dividend), operand b
//   flush                : kill any in-flight operation
//   resp_valid           : one-cycle result pulse, no backpressure
//   resp_result/resp_rd  : result and its destination, held between pulses
//   resp_err             : unsupported func3, qualified by resp_valid
//   stall                : pipeline hold while the sequencer is computing
// modport master : execute-stage side (drives requests and flush)
// modport slave  : sequencer side
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_func3;
  logic [4:0]      req_rd;
  logic [XLEN-1:0] req_rs1_val;
  logic [XLEN-1:0] req_rs2_val;
  logic            flush;
  logic            resp_valid;
  logic [XLEN-1:0] resp_result;
  logic [4:0]      resp_rd;
  logic            resp_err;
  logic            stall;

  modport master (
    output req_valid, req_func3, req_rd, req_rs1_val, req_rs2_val, flush,
    input  req_ready, resp_valid, resp_result, resp_rd, resp_err, stall
  );

  modport slave (
    input  req_valid, req_func3, req_rd, req_rs1_val, req_rs2_val, flush,
    output req_ready, resp_valid, resp_result, resp_rd, resp_err, stall
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative RV32M sequencer: MUL, MULH, DIV, DIVU, REM, REMU. Normal ops run a
// 32-step shift-add multiply or restoring divide (IDLE -> CALC x32 -> FIX ->
// DONE). Divide-by-zero, signed overflow and unsupported func3 skip straight
// to DONE with the architecturally defined result.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset, dominates flush and requests
//   bus  : muldiv_sequencer_if.slave (request, response, flush, stall)
module muldiv_sequencer (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_MULH = 3'b001;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  state_t      state, state_next;
  logic [5:0]  cnt;

  // Latched operation. op_a holds the multiplicand / dividend and, during a
  // divide, collects quotient bits from the LSB as dividend bits leave the MSB.
  logic [2:0]  func3_q;
  logic [4:0]  rd_q;
  logic        neg_a, neg_b;
  logic [31:0] op_a, op_b;
  logic [63:0] acc;    // product; low half is the partial remainder on divide
  logic [63:0] mcand;  // multiplicand shifted left one place per step

  logic        accept;
  logic        req_unsup, req_div, req_signed, req_div0, req_ovf, req_fast;
  logic [31:0] a_mag, b_mag, fast_result;

  logic [32:0] rem_shift, rem_diff;
  logic        rem_ge;

  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, fix_result;

  logic        resp_valid_d, stall_d, resp_err_d;
  logic [31:0] resp_result_d;
  logic [4:0]  resp_rd_d;

  assign bus.req_ready = (state == S_IDLE);
  assign accept        = bus.req_valid && (state == S_IDLE) && !bus.flush;

  // Request decode and fast-path results, evaluated on the raw request.
  // NOTE: every always_comb output gets a default at the top so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    req_unsup   = (bus.req_func3[2:1] == 2'b01);
    req_div     = bus.req_func3[2];
    req_signed  = (bus.req_func3 == F3_MULH) || (bus.req_func3 == F3_DIV) ||
                  (bus.req_func3 == F3_REM);
    req_div0    = req_div && (bus.req_rs2_val == 32'd0);
    req_ovf     = req_div && !bus.req_func3[0] &&
                  (bus.req_rs1_val == 32'h8000_0000) &&
                  (bus.req_rs2_val == 32'hFFFF_FFFF);
    req_fast    = req_unsup || req_div0 || req_ovf;
    a_mag       = (req_signed && bus.req_rs1_val[31]) ? -bus.req_rs1_val : bus.req_rs1_val;
    b_mag       = (req_signed && bus.req_rs2_val[31]) ? -bus.req_rs2_val : bus.req_rs2_val;
    fast_result = '0;
    if (req_div0)     fast_result = bus.req_func3[1] ? bus.req_rs1_val : 32'hFFFF_FFFF;
    else if (req_ovf) fast_result = bus.req_func3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One restoring-divide step: bring in the next dividend bit, subtract the
  // divisor when it fits. The shifted remainder needs 33 bits to compare.
  always_comb begin
    rem_shift = {acc[31:0], op_a[31]};
    rem_diff  = rem_shift - {1'b0, op_b};
    rem_ge    = (rem_shift >= {1'b0, op_b});
  end

  // Sign fixup and result select for the FIX state.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quot_fix = (neg_a ^ neg_b) ? -op_a : op_a;
    rem_fix  = neg_a ? -acc[31:0] : acc[31:0];
    case (func3_q)
      F3_MUL:  fix_result = acc[31:0];
      F3_MULH: fix_result = prod_fix[63:32];
      F3_DIV:  fix_result = quot_fix;
      F3_DIVU: fix_result = op_a;
      F3_REM:  fix_result = rem_fix;
      F3_REMU: fix_result = acc[31:0];
      default: fix_result = '0;
    endcase
  end

  // FSM: next-state logic. flush overrides everything except reset.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = req_fast ? S_DONE : S_CALC;
      S_CALC:  if (cnt == 6'd31) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (bus.flush) state_next = S_IDLE;
  end

  // FSM: output logic. All outputs except req_ready are registered, so the
  // values here are what they become on entry to the next state.
  always_comb begin
    resp_valid_d  = (state_next == S_DONE);
    stall_d       = (state_next == S_CALC) || (state_next == S_FIX);
    resp_result_d = fix_result;
    resp_rd_d     = rd_q;
    resp_err_d    = 1'b0;
    if (state == S_IDLE) begin
      resp_result_d = fast_result;
      resp_rd_d     = bus.req_rd;
      resp_err_d    = req_unsup;
    end
  end

  // FSM: state register plus registered outputs and step counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bus.resp_valid  <= 1'b0;
      bus.stall       <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_rd     <= '0;
      bus.resp_err    <= 1'b0;
    end else begin
      state          <= state_next;
      bus.resp_valid <= resp_valid_d;
      bus.stall      <= stall_d;
      if (resp_valid_d) begin
        bus.resp_result <= resp_result_d;
        bus.resp_rd     <= resp_rd_d;
        bus.resp_err    <= resp_err_d;
      end
      // Exit is decided at 31; the counter holds there instead of wrapping.
      if (accept)                                cnt <= '0;
      else if (state == S_CALC && cnt != 6'd31)  cnt <= cnt + 6'd1;
    end
  end

  // Datapath.
  // NOTE: operand and accumulator registers are not reset; every field is
  // loaded on accept before anything reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      func3_q <= bus.req_func3;
      rd_q    <= bus.req_rd;
      neg_a   <= req_signed && bus.req_rs1_val[31];
      neg_b   <= req_signed && bus.req_rs2_val[31];
      op_a    <= a_mag;
      op_b    <= b_mag;
      acc     <= '0;
      mcand   <= {32'd0, a_mag};
    end else if (state == S_CALC) begin
      if (func3_q[2]) begin
        acc[31:0] <= rem_ge ? rem_diff[31:0] : rem_shift[31:0];
        op_a      <= {op_a[30:0], rem_ge};
      end else begin
        if (op_b[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        op_b  <= op_b >> 1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle (cycle T); returns at the negedge of T+1.
  task automatic start_req(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check({tag, "_ready"}, bus.req_ready, 1);
    bus.req_valid   = 1'b1;
    bus.req_func3   = f3;
    bus.req_rd      = rd;
    bus.req_rs1_val = a;
    bus.req_rs2_val = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Called at the negedge of T+1; k is the cycle offset from accept.
  task automatic wait_resp(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_rd,
                           input logic exp_err, input int exp_lat, input int exp_stall);
    int  k = 1;
    int  stall_cnt = 0;
    bit  got = 0;
    while (!got && k <= 40) begin
      if (bus.stall) stall_cnt++;
      if (bus.resp_valid) got = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check({tag, "_resp_seen"}, got, 1);
    if (got) begin
      check({tag, "_result"}, bus.resp_result, exp_res);
      check({tag, "_rd"}, bus.resp_rd, exp_rd);
      check({tag, "_err"}, bus.resp_err, exp_err);
      check({tag, "_latency"}, k, exp_lat);
      check({tag, "_stall_cycles"}, stall_cnt, exp_stall);
      check({tag, "_ready_in_done"}, bus.req_ready, 0);
      @(negedge clk);
      check({tag, "_pulse_one_cycle"}, bus.resp_valid, 0);
      check({tag, "_result_held"}, bus.resp_result, exp_res);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_err, input bit fast);
    start_req(tag, f3, rd, a, b);
    wait_resp(tag, exp_res, rd, exp_err, fast ? 1 : 34, fast ? 0 : 33);
  endtask

  task automatic count_idle_resp(input string tag, input int cycles);
    int n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.resp_valid) n++;
    end
    check(tag, n, 0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_func3   = '0;
    bus.req_rd      = '0;
    bus.req_rs1_val = '0;
    bus.req_rs2_val = '0;
    bus.flush       = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", bus.req_ready, 1);
    check("reset_valid", bus.resp_valid, 0);
    check("reset_stall", bus.stall, 0);
    check("reset_err", bus.resp_err, 0);
    check("reset_result", bus.resp_result, 0);
    check("reset_rd", bus.resp_rd, 0);

    // Normal multi-cycle operations
    run_op("mul_7_neg3", 3'b000, 5'd5, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op("mulh_min_min", 3'b001, 5'd6, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
    run_op("mulh_m1_1", 3'b001, 5'd7, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mulh_2p16_sq", 3'b001, 5'd8, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0);
    run_op("div_m7_2", 3'b100, 5'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("rem_m7_2", 3'b110, 5'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_100_7", 3'b101, 5'd12, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
    run_op("remu_100_7", 3'b111, 5'd13, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
    run_op("divu_max_1", 3'b101, 5'd14, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Fast path
    run_op("div_5_0", 3'b100, 5'd15, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("rem_5_0", 3'b110, 5'd16, 32'd5, 32'd0, 32'd5, 1'b0, 1'b1);
    run_op("div_ovf", 3'b100, 5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
    run_op("rem_ovf", 3'b110, 5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    run_op("unsup_010", 3'b010, 5'd19, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);

    // Flush on the 10th CALC cycle (T+10)
    start_req("flush_calc", 3'b101, 5'd20, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_calc_ready", bus.req_ready, 1);
    check("flush_calc_stall", bus.stall, 0);
    check("flush_calc_valid", bus.resp_valid, 0);
    count_idle_resp("flush_calc_no_resp", 40);
    run_op("divu_9_3", 3'b101, 5'd21, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0);

    // Flush together with req_valid: request dropped
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.flush       = 1'b1;
    bus.req_func3   = 3'b000;
    bus.req_rd      = 5'd22;
    bus.req_rs1_val = 32'd2;
    bus.req_rs2_val = 32'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    check("flush_req_ready", bus.req_ready, 1);
    check("flush_req_stall", bus.stall, 0);
    count_idle_resp("flush_req_no_resp", 5);

    // Reset mid-CALC
    start_req("rst_calc", 3'b000, 5'd9, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_calc_ready", bus.req_ready, 1);
    check("rst_calc_valid", bus.resp_valid, 0);
    check("rst_calc_stall", bus.stall, 0);
    check("rst_calc_err", bus.resp_err, 0);
    check("rst_calc_result", bus.resp_result, 0);
    check("rst_calc_rd", bus.resp_rd, 0);
    rst = 1'b0;
    count_idle_resp("rst_calc_no_resp", 40);
    run_op("mul_3_4", 3'b000, 5'd2, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
